hana_i2c_master: RTL and testbench
==================================

Name: hana_i2c_master

Overview:
- Parametrised successor to the fixed-bitstream HANA slowdown injector.
- Generates real I2C write transactions (START, address+W, register byte, 1..4 data bytes, STOP) from parameters instead of a hard-coded 256-bit pattern.
- Samples ACK, retries on NAK and reports status.
- Sits between the glitch sequencer (level request: slow/fast) and the HANA SDA/SCL open-drain pads, clocked from the 400 kHz domain.

Parameters:
- DEV_ADDR, 7'h70, 7-bit HANA slave address.
- SLOW_REG, 8'hCD, register written for slowdown.
- FAST_REG, 8'hCD, register written for speedup.
- DATA_BYTES, 4, data bytes per message (1..4).
- SLOW_DATA, 32'h04_00_00_4E, slowdown payload, MSB byte sent first; only the top DATA_BYTES bytes are used.
- FAST_DATA, 32'h04_00_00_0E, speedup payload, same packing.
- SLOW_DELAY_MS, 31, delay before a slowdown message, in ms (0..255).
- TICKS_PER_MS, 400, clk_400k cycles per ms.
- MAX_RETRIES, 3, resend attempts after a NAK before error.
- BUS_FREE, 8, cycles idle between STOP and the next START.

Ports:
- clk_400k  in  1  block clock, 400 kHz.
- rst  in  1  synchronous reset, active-high.
- i2c_send  in  1  requested state: 1 = slowdown, 0 = speedup.
- i2c_sda_io  inout  1  open-drain SDA: drives 0 or Z; read back for ACK.
- i2c_scl_io  inout  1  open-drain SCL: drives 0 or Z; read back only with the stretch option.
- busy  out  1  high from leaving IDLE until return to IDLE.
- done  out  1  one-cycle pulse when a message completes with all ACKs.
- nak_err  out  1  sticky; set when retries are exhausted, cleared by rst or the next successful message.
- cur_state  out  1  last successfully sent request (mirrors i2c_send once applied).

Behaviour:
- Reset, applied on any cycle, including mid-transfer:
  - SDA and SCL released (Z); busy=0, done=0, nak_err=0, cur_state=0.
  - FSM returns to IDLE; all counters cleared.
- A partial transfer cut by reset is abandoned with no STOP. The bus is left released.
- Bit timing: 4 phases per bit, giving 100 kHz SCL.
  - Ph0: SCL low, update SDA.
  - Ph1: SCL low.
  - Ph2: SCL released.
  - Ph3: SCL released; sample SDA here for ACK.
- FSM states:
  - IDLE: if i2c_send != cur_state and the BUS_FREE gap has elapsed:
    - i2c_send=1 and SLOW_DELAY_MS>0 -> DELAY.
    - otherwise -> START.
  - DELAY: counts SLOW_DELAY_MS*TICKS_PER_MS cycles.
    - If i2c_send returns to cur_state during the count -> IDLE, no transaction.
    - At terminal count -> START.
  - START: SDA low while SCL high for 2 cycles, then SCL low -> BYTE. The message is latched at START; later i2c_send changes do not affect the current transfer.
  - BYTE: shifts 8 bits MSB-first. Byte order: {DEV_ADDR,0}, then reg, then the DATA_BYTES data bytes.
  - ACK: SDA released for one bit; sampled at Ph3.
    - Sample 0 -> next byte, or STOP after the last byte.
    - Sample 1 (NAK) -> STOP, then retry.
  - STOP: SDA low with SCL high, then SDA released (2 cycles) -> GAP.
  - GAP: BUS_FREE cycles idle.
    - After success: cur_state <= latched request; done pulses on the GAP entry cycle.
    - After a NAK with retry count < MAX_RETRIES: increment the count, -> START.
    - Retries exhausted: nak_err<=1, cur_state unchanged, -> IDLE. The FSM retries from IDLE only when i2c_send toggles again.
- Request toggling during a transfer: the current message completes. In IDLE the new level is compared against cur_state, so only the latest level is sent. Toggle 0->1->0 mid-transfer of fast: nothing further is sent.
- Retry count resets on every new request.
- Width rules:
  - DELAY counter width is clog2(255*TICKS_PER_MS+1).
  - The byte index covers 2+DATA_BYTES.
  - DATA_BYTES outside 1..4 is a synthesis error; use a generate-time check.

Optional Feature:
- HANA_I2C_STRETCH_EN defined: in Ph2/Ph3 the phase counter holds while SCL reads back 0 (slave clock stretching).
- Without the macro: SCL readback is ignored and timing is fixed at 4 cycles per bit.

Test Plan:
- rst mid-DELAY, then release -> both lines Z, busy=0; no START seen within 100 cycles.
- i2c_send 0->1, slave ACKs all -> START after exactly 31*400 cycles; bytes E0, CD, 04, 00, 00, 4E observed; done pulse; cur_state=1.
- i2c_send 1->0 after success, ACK -> START within BUS_FREE+2 cycles, no delay; payload ends 0E; cur_state=0.
- Slave NAKs the address always -> 4 START/STOP attempts total; nak_err=1; cur_state unchanged; no done pulse.
- i2c_send 0->1 then back to 0 at 10 ms -> returns to IDLE; no bus activity; busy falls.
- HANA_I2C_STRETCH_EN, slave holds SCL low 20 cycles during byte 2 -> bit period extended by 20; data intact; done pulses.

Source files
------------

// File: rtl/hana_i2c_master.sv
// hana_i2c_master: parametrised I2C write master driving the HANA slowdown/speedup register.
// Sends START, {DEV_ADDR,W}, reg, DATA_BYTES data bytes, STOP; checks ACKs and retries on NAK.
// Ports: clk_400k/rst (sync, active-high), i2c_send (1=slow, 0=fast),
//        i2c_sda_io/i2c_scl_io (open-drain), busy, done (pulse), nak_err (sticky), cur_state.
// Optional: define HANA_I2C_STRETCH_EN to honour slave clock stretching in Ph2/Ph3.

module hana_i2c_master #(
    parameter logic [6:0]  DEV_ADDR      = 7'h70,
    parameter logic [7:0]  SLOW_REG      = 8'hCD,
    parameter logic [7:0]  FAST_REG      = 8'hCD,
    parameter int          DATA_BYTES    = 4,
    parameter logic [31:0] SLOW_DATA     = 32'h04_00_00_4E,
    parameter logic [31:0] FAST_DATA     = 32'h04_00_00_0E,
    parameter int          SLOW_DELAY_MS = 31,
    parameter int          TICKS_PER_MS  = 400,
    parameter int          MAX_RETRIES   = 3,
    parameter int          BUS_FREE      = 8
) (
    input  logic clk_400k,
    input  logic rst,
    input  logic i2c_send,
    inout  wire  i2c_sda_io,
    inout  wire  i2c_scl_io,
    output logic busy,
    output logic done,
    output logic nak_err,
    output logic cur_state
);

    if (DATA_BYTES < 1 || DATA_BYTES > 4) begin : g_bad_data_bytes
        $error("hana_i2c_master: DATA_BYTES must be 1..4");
    end

    localparam int NB      = 2 + DATA_BYTES;
    localparam int BW      = $clog2(NB + 1);
    localparam int DW      = $clog2(255 * TICKS_PER_MS + 1);
    localparam int RW      = $clog2(MAX_RETRIES + 2);
    localparam int DLY_CYC = SLOW_DELAY_MS * TICKS_PER_MS;

    localparam logic [DW-1:0] DLY_LAST  = DW'(DLY_CYC - 1);
    localparam logic [DW-1:0] GAP_LAST  = DW'(BUS_FREE - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_START,
        S_BYTE,
        S_ACK,
        S_STOP,
        S_GAP
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [DW-1:0]   cnt;
    logic [1:0]      ph;
    logic [2:0]      bit_cnt;
    logic [BW-1:0]   byte_idx;
    logic [RW-1:0]   retry;
    logic            req_q;
    logic            nak_q;
    logic            blocked;
    logic            blk_lvl;
    logic            sda_low;
    logic            scl_low;
    logic            sda_in;
    logic            hold;
    logic            go;
    logic [47:0]     msg;
    logic [7:0]      tx_byte;

    assign i2c_sda_io = sda_low ? 1'b0 : 1'bz;
    assign i2c_scl_io = scl_low ? 1'b0 : 1'bz;
    assign sda_in     = i2c_sda_io;
    assign busy       = (state != S_IDLE);

`ifdef HANA_I2C_STRETCH_EN
    // Slave holding SCL low while we release it freezes the bit phase.
    assign hold = ph[1] & ~i2c_scl_io;
`else
    assign hold = 1'b0;
`endif

    // After an exhausted retry the failed level is ignored until the request moves away.
    assign go = (i2c_send != cur_state) && !(blocked && (i2c_send == blk_lvl));

    // Whole message packed MSB-first; byte_idx walks it from the address byte down.
    assign msg = {DEV_ADDR, 1'b0,
                  req_q ? SLOW_REG : FAST_REG,
                  req_q ? SLOW_DATA : FAST_DATA};
    assign tx_byte = msg[8 * (5 - int'(byte_idx)) +: 8];

    always_comb begin
        state_n = state;
        sda_low = 1'b0;
        scl_low = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (go) begin
                    state_n = (i2c_send && (DLY_CYC > 0)) ? S_DELAY : S_START;
                end
            end
            S_DELAY: begin
                if (i2c_send == cur_state) begin
                    state_n = S_IDLE;
                end else if (cnt == DLY_LAST) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                sda_low = 1'b1;
                if (cnt == DW'(1)) begin
                    state_n = S_BYTE;
                end
            end
            S_BYTE: begin
                sda_low = ~tx_byte[~bit_cnt];
                scl_low = ~ph[1];
                if (ph == 2'd3 && !hold && bit_cnt == 3'd7) begin
                    state_n = S_ACK;
                end
            end
            S_ACK: begin
                scl_low = ~ph[1];
                if (ph == 2'd3 && !hold) begin
                    state_n = (sda_in || byte_idx == LAST_BYTE) ? S_STOP : S_BYTE;
                end
            end
            S_STOP: begin
                // First cycle pulls SCL low so SDA can fall without a false START.
                sda_low = 1'b1;
                scl_low = (cnt == '0);
                if (cnt == DW'(1)) begin
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = (nak_q && retry < RETRY_MAX) ? S_START : S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_400k) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ph        <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            retry     <= '0;
            req_q     <= 1'b0;
            nak_q     <= 1'b0;
            blocked   <= 1'b0;
            blk_lvl   <= 1'b0;
            done      <= 1'b0;
            nak_err   <= 1'b0;
            cur_state <= 1'b0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            cnt   <= (state_n != state) ? '0 : cnt + 1'b1;

            if (state_n != state) begin
                ph <= '0;
            end else if ((state == S_BYTE || state == S_ACK) && !hold) begin
                ph <= ph + 1'b1;
            end

            if (state == S_BYTE && ph == 2'd3 && !hold) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state == S_ACK && state_n == S_BYTE) begin
                byte_idx <= byte_idx + 1'b1;
            end

            if (state == S_ACK && ph == 2'd3 && !hold && sda_in) begin
                nak_q <= 1'b1;
            end

            // Message is frozen here; a retry reuses it, a fresh request restarts the count.
            if (state_n == S_START && state != S_START) begin
                bit_cnt  <= '0;
                byte_idx <= '0;
                nak_q    <= 1'b0;
                if (state == S_GAP) begin
                    retry <= retry + 1'b1;
                end else begin
                    retry <= '0;
                    req_q <= i2c_send;
                end
            end

            if (blocked && i2c_send != blk_lvl) begin
                blocked <= 1'b0;
            end

            if (state == S_STOP && state_n == S_GAP) begin
                if (!nak_q) begin
                    done      <= 1'b1;
                    cur_state <= req_q;
                    nak_err   <= 1'b0;
                end else if (retry == RETRY_MAX) begin
                    nak_err <= 1'b1;
                    blocked <= 1'b1;
                    blk_lvl <= req_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_hana_i2c_master.sv
// tb_hana_i2c_master: directed bench for hana_i2c_master with a bus-level I2C slave model.
// Checks delay, byte stream, ACK/NAK retry, abort, request toggling and (optionally) stretching.

module tb_hana_i2c_master;

    localparam int N_DLY   = 31 * 400;
    localparam int MSG_LEN = 2 + 6 * 36 + 2;

    logic clk_400k = 1'b0;
    logic rst      = 1'b1;
    logic i2c_send = 1'b0;
    logic busy;
    logic done;
    logic nak_err;
    logic cur_state;
    wire  sda_bus;
    wire  scl_bus;

    logic slv_sda_low = 1'b0;
    logic slv_scl_low = 1'b0;
    logic nak_addr    = 1'b0;
    logic stretch_en  = 1'b0;

    assign sda_bus = slv_sda_low ? 1'b0 : 1'bz;
    assign scl_bus = slv_scl_low ? 1'b0 : 1'bz;
    pullup (sda_bus);
    pullup (scl_bus);

    hana_i2c_master dut (
        .clk_400k   (clk_400k),
        .rst        (rst),
        .i2c_send   (i2c_send),
        .i2c_sda_io (sda_bus),
        .i2c_scl_io (scl_bus),
        .busy       (busy),
        .done       (done),
        .nak_err    (nak_err),
        .cur_state  (cur_state)
    );

    always #5 clk_400k = ~clk_400k;

    int cyc = 0;
    always @(posedge clk_400k) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got_v,
                             input logic [31:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    // Bus monitor and slave, sampled on the falling clock edge.
    int         n_start = 0;
    int         n_stop  = 0;
    int         n_done  = 0;
    int         bitc    = 0;
    int         nbyte   = 0;
    int         t_start = 0;
    int         t_done  = 0;
    int         stretch_left = 0;
    logic       p_sda = 1'b1;
    logic       p_scl = 1'b1;
    logic [7:0] shreg = 8'h00;
    logic [7:0] got [0:15];

    always @(negedge clk_400k) begin
        logic s;
        logic c;
        s = sda_bus;
        c = scl_bus;
        if (done) begin
            n_done++;
            t_done = cyc;
        end
        if (stretch_left > 0) begin
            stretch_left--;
            if (stretch_left == 0) slv_scl_low = 1'b0;
        end
        if (p_scl && c && p_sda && !s) begin
            n_start++;
            t_start = cyc;
            bitc = 0;
            nbyte = 0;
            slv_sda_low = 1'b0;
        end else if (p_scl && c && !p_sda && s) begin
            n_stop++;
            bitc = 0;
            slv_sda_low = 1'b0;
        end else if (!p_scl && c) begin
            if (bitc < 8) shreg = {shreg[6:0], s};
            bitc++;
            if (bitc == 8 && nbyte < 16) begin
                got[nbyte] = shreg;
                nbyte++;
            end
        end else if (p_scl && !c) begin
            if (bitc == 8) begin
                slv_sda_low = !(nak_addr && nbyte == 1);
            end else if (bitc == 9) begin
                slv_sda_low = 1'b0;
                bitc = 0;
                // Pulled during Ph0, two cycles before the master lets SCL go: net +20.
                if (stretch_en && nbyte == 2) begin
                    slv_scl_low = 1'b1;
                    stretch_left = 22;
                end
            end
        end
        p_sda = s;
        p_scl = c;
    end

    task automatic wait_start(input string tag, input int s0, input int lim);
        int i = 0;
        while (n_start == s0 && i < lim) begin
            @(negedge clk_400k);
            i++;
        end
        expect_eq(tag, 32'(n_start != s0), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int d0, input int lim);
        int i = 0;
        while (n_done == d0 && i < lim) begin
            @(negedge clk_400k);
            i++;
        end
        expect_eq(tag, 32'(n_done != d0), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int i = 0;
        while (busy && i < lim) begin
            @(negedge clk_400k);
            i++;
        end
        expect_eq(tag, 32'(busy), 32'd0);
    endtask

    logic [7:0] slow_exp [0:5] = '{8'hE0, 8'hCD, 8'h04, 8'h00, 8'h00, 8'h4E};
    logic [7:0] fast_exp [0:5] = '{8'hE0, 8'hCD, 8'h04, 8'h00, 8'h00, 8'h0E};

    initial begin
        int s0;
        int d0;
        int p0;
        int c0;

        // Reset state
        repeat (3) @(negedge clk_400k);
        expect_eq("rst_sda", 32'(sda_bus), 32'd1);
        expect_eq("rst_scl", 32'(scl_bus), 32'd1);
        expect_eq("rst_busy", 32'(busy), 32'd0);
        expect_eq("rst_done", 32'(done), 32'd0);
        expect_eq("rst_nak_err", 32'(nak_err), 32'd0);
        expect_eq("rst_cur_state", 32'(cur_state), 32'd0);
        rst = 1'b0;

        // Reset mid-DELAY
        i2c_send = 1'b1;
        repeat (100) @(negedge clk_400k);
        expect_eq("dly_busy", 32'(busy), 32'd1);
        expect_eq("dly_no_start", 32'(n_start), 32'd0);
        rst = 1'b1;
        i2c_send = 1'b0;
        @(negedge clk_400k);
        rst = 1'b0;
        expect_eq("rstdly_sda", 32'(sda_bus), 32'd1);
        expect_eq("rstdly_scl", 32'(scl_bus), 32'd1);
        expect_eq("rstdly_busy", 32'(busy), 32'd0);
        repeat (100) @(negedge clk_400k);
        expect_eq("rstdly_no_start", 32'(n_start), 32'd0);
        expect_eq("rstdly_busy_late", 32'(busy), 32'd0);

        // Slowdown, all ACKed
        s0 = n_start;
        d0 = n_done;
        c0 = cyc;
        i2c_send = 1'b1;
        wait_start("slow_start_seen", s0, N_DLY + 200);
        expect_eq("slow_delay", 32'(t_start - c0 - 1), 32'(N_DLY));
        wait_done("slow_done_seen", d0, 400);
        for (int i = 0; i < 6; i++) begin
            expect_eq($sformatf("slow_byte%0d", i), 32'(got[i]), 32'(slow_exp[i]));
        end
        expect_eq("slow_nbytes", 32'(nbyte), 32'd6);
        expect_eq("slow_len", 32'(t_done - t_start), 32'(MSG_LEN));
        expect_eq("slow_cur_state", 32'(cur_state), 32'd1);
        expect_eq("slow_nak_err", 32'(nak_err), 32'd0);

        // Speedup requested during the bus-free gap
        s0 = n_start;
        d0 = n_done;
        c0 = cyc;
        i2c_send = 1'b0;
        wait_start("fast_start_seen", s0, 50);
        expect_eq("fast_no_delay", 32'((t_start - c0 - 1) <= 10), 32'd1);
        wait_done("fast_done_seen", d0, 400);
        for (int i = 0; i < 6; i++) begin
            expect_eq($sformatf("fast_byte%0d", i), 32'(got[i]), 32'(fast_exp[i]));
        end
        expect_eq("fast_len", 32'(t_done - t_start), 32'(MSG_LEN));
        expect_eq("fast_cur_state", 32'(cur_state), 32'd0);
        expect_eq("fast_done_once", 32'(n_done - d0), 32'd1);
        wait_idle("fast_idle", 50);

        // Address always NAKed
        nak_addr = 1'b1;
        s0 = n_start;
        p0 = n_stop;
        d0 = n_done;
        i2c_send = 1'b1;
        wait_start("nak_start_seen", s0, N_DLY + 200);
        wait_idle("nak_idle", 2000);
        repeat (100) @(negedge clk_400k);
        expect_eq("nak_starts", 32'(n_start - s0), 32'd4);
        expect_eq("nak_stops", 32'(n_stop - p0), 32'd4);
        expect_eq("nak_err_set", 32'(nak_err), 32'd1);
        expect_eq("nak_cur_state", 32'(cur_state), 32'd0);
        expect_eq("nak_no_done", 32'(n_done - d0), 32'd0);
        expect_eq("nak_stays_idle", 32'(busy), 32'd0);

        // Request withdrawn during the delay
        nak_addr = 1'b0;
        i2c_send = 1'b0;
        repeat (5) @(negedge clk_400k);
        s0 = n_start;
        i2c_send = 1'b1;
        repeat (4000) @(negedge clk_400k);
        expect_eq("abort_busy", 32'(busy), 32'd1);
        i2c_send = 1'b0;
        repeat (3) @(negedge clk_400k);
        expect_eq("abort_idle", 32'(busy), 32'd0);
        expect_eq("abort_no_start", 32'(n_start - s0), 32'd0);
        expect_eq("abort_nak_sticky", 32'(nak_err), 32'd1);

        // Successful slowdown clears the sticky error
        s0 = n_start;
        d0 = n_done;
        i2c_send = 1'b1;
        wait_start("rec_start_seen", s0, N_DLY + 200);
        wait_done("rec_done_seen", d0, 400);
        expect_eq("rec_nak_clear", 32'(nak_err), 32'd0);
        expect_eq("rec_cur_state", 32'(cur_state), 32'd1);

        // 0->1->0 toggle during a speedup transfer sends nothing more
        s0 = n_start;
        d0 = n_done;
        i2c_send = 1'b0;
        wait_start("tog_start_seen", s0, 50);
        repeat (50) @(negedge clk_400k);
        i2c_send = 1'b1;
        repeat (10) @(negedge clk_400k);
        i2c_send = 1'b0;
        wait_done("tog_done_seen", d0, 400);
        repeat (100) @(negedge clk_400k);
        expect_eq("tog_one_start", 32'(n_start - s0), 32'd1);
        expect_eq("tog_cur_state", 32'(cur_state), 32'd0);
        expect_eq("tog_idle", 32'(busy), 32'd0);

`ifdef HANA_I2C_STRETCH_EN
        // Slave stretches SCL by 20 cycles on the first data byte
        stretch_en = 1'b1;
        s0 = n_start;
        d0 = n_done;
        i2c_send = 1'b1;
        wait_start("str_start_seen", s0, N_DLY + 200);
        wait_done("str_done_seen", d0, 600);
        expect_eq("str_len", 32'(t_done - t_start), 32'(MSG_LEN + 20));
        for (int i = 0; i < 6; i++) begin
            expect_eq($sformatf("str_byte%0d", i), 32'(got[i]), 32'(slow_exp[i]));
        end
        expect_eq("str_cur_state", 32'(cur_state), 32'd1);
        stretch_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
